// File: rtl/wsp_pkg.sv
// Shared types and constants for the wrapper serial port sequencer.
// The state encoding is common to the FSM and anything that observes it.
package wsp_pkg;

  localparam int MAX_LEN_DEF = 64;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CAPTURE = 3'd1,
    SHIFT   = 3'd2,
    UPDATE  = 3'd3,
    RESP    = 3'd4
  } wsp_state_e;

endpackage

// File: rtl/wsp_sequencer_if.sv
// Command/response handshake plus WSP strobes between host, sequencer and chain.
// slave = sequencer side, master = host/chain side.
interface wsp_sequencer_if #(
  parameter int MAX_LEN = wsp_pkg::MAX_LEN_DEF,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
);

  logic               cmd_valid;
  logic               cmd_ready;
  logic               cmd_sel_wir;
  logic [LEN_W-1:0]   cmd_len;
  logic [MAX_LEN-1:0] cmd_data;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [MAX_LEN-1:0] rsp_data;
  logic               rsp_err;
  logic               select_wir;
  logic               capture_wr;
  logic               shift_wr;
  logic               update_wr;
  logic               wsi;
  logic               wso;

  modport slave (
    input  cmd_valid, cmd_sel_wir, cmd_len, cmd_data, rsp_ready, wso,
    output cmd_ready, rsp_valid, rsp_data, rsp_err,
           select_wir, capture_wr, shift_wr, update_wr, wsi
  );

  modport master (
    output cmd_valid, cmd_sel_wir, cmd_len, cmd_data, rsp_ready, wso,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err,
           select_wir, capture_wr, shift_wr, update_wr, wsi
  );

endinterface

// File: rtl/wsp_shifter.sv
// Shift-in data register, shift-out response register and bit counter.
// o_next_bit exposes the bit that becomes current after the next shift edge.
module wsp_shifter
  import wsp_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               arst_n,
  input  logic               i_load,
  input  logic [LEN_W-1:0]   i_len,
  input  logic [MAX_LEN-1:0] i_data,
  input  logic               i_shift_en,
  input  logic               i_wso,
  output logic               o_cur_bit,
  output logic               o_next_bit,
  output logic               o_last,
  output logic               o_len_zero,
  output logic [MAX_LEN-1:0] o_rsp
);

  logic [MAX_LEN-1:0] r_data;
  logic [MAX_LEN-1:0] r_rsp;
  logic [LEN_W-1:0]   r_cnt;
  logic [LEN_W-1:0]   r_len;

  // Load on acceptance (response cleared so unshifted bits read 0), shift one bit per enable.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_data <= {MAX_LEN{1'b0}};
      r_rsp  <= {MAX_LEN{1'b0}};
      r_cnt  <= {LEN_W{1'b0}};
      r_len  <= {LEN_W{1'b0}};
    end else if (i_load) begin
      r_data <= i_data;
      r_rsp  <= {MAX_LEN{1'b0}};
      r_cnt  <= {LEN_W{1'b0}};
      r_len  <= i_len;
    end else if (i_shift_en) begin
      r_data <= r_data >> 1;
      r_cnt  <= r_cnt + LEN_W'(1);
      for (int i = 0; i < MAX_LEN; i++) begin
        if (r_cnt == LEN_W'(i)) begin
          r_rsp[i] <= i_wso;
        end
      end
    end
  end

  assign o_cur_bit  = r_data[0];
  assign o_next_bit = r_data[1];
  assign o_last     = ((r_cnt + LEN_W'(1)) == r_len);
  assign o_len_zero = (r_len == {LEN_W{1'b0}});
  assign o_rsp      = r_rsp;

endmodule

// File: rtl/wsp_sequencer.sv
// WSP initiator: runs one capture/shift/update scan per accepted command
// and returns the sampled wso bits on the response handshake.
module wsp_sequencer
  import wsp_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic            clk,
  input  logic            arst_n,
  wsp_sequencer_if.slave  bus
);

  wsp_state_e r_state;
  logic       r_cmd_ready;
  logic       r_rsp_valid;
  logic       r_rsp_err;
  logic       r_select_wir;
  logic       r_capture_wr;
  logic       r_shift_wr;
  logic       r_update_wr;
  logic       r_wsi;

  logic               w_accept;
  logic [LEN_W-1:0]   w_len;
  logic               w_err;
  logic               w_cur_bit;
  logic               w_next_bit;
  logic               w_last;
  logic               w_len_zero;
  logic [MAX_LEN-1:0] w_rsp;

  assign w_accept = (r_state == IDLE) && bus.cmd_valid && r_cmd_ready;

  // Overlong requests are clamped to the chain length and flagged.
  always_comb begin
    w_len = bus.cmd_len;
    w_err = 1'b0;
    if (bus.cmd_len > LEN_W'(MAX_LEN)) begin
      w_len = LEN_W'(MAX_LEN);
      w_err = 1'b1;
    end else begin
      w_len = bus.cmd_len;
      w_err = 1'b0;
    end
  end

  wsp_shifter #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_shifter (
    .clk        (clk),
    .arst_n     (arst_n),
    .i_load     (w_accept),
    .i_len      (w_len),
    .i_data     (bus.cmd_data),
    .i_shift_en (r_shift_wr),
    .i_wso      (bus.wso),
    .o_cur_bit  (w_cur_bit),
    .o_next_bit (w_next_bit),
    .o_last     (w_last),
    .o_len_zero (w_len_zero),
    .o_rsp      (w_rsp)
  );

  // Scan FSM; every strobe is set one edge ahead of the state it belongs to.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state      <= IDLE;
      r_cmd_ready  <= 1'b1;
      r_rsp_valid  <= 1'b0;
      r_rsp_err    <= 1'b0;
      r_select_wir <= 1'b0;
      r_capture_wr <= 1'b0;
      r_shift_wr   <= 1'b0;
      r_update_wr  <= 1'b0;
      r_wsi        <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state      <= CAPTURE;
            r_cmd_ready  <= 1'b0;
            r_capture_wr <= 1'b1;
            r_select_wir <= bus.cmd_sel_wir;
            r_rsp_err    <= w_err;
          end
        end
        CAPTURE: begin
          r_capture_wr <= 1'b0;
          if (w_len_zero) begin
            r_state     <= UPDATE;
            r_update_wr <= 1'b1;
          end else begin
            r_state    <= SHIFT;
            r_shift_wr <= 1'b1;
            r_wsi      <= w_cur_bit;
          end
        end
        SHIFT: begin
          if (w_last) begin
            r_state     <= UPDATE;
            r_shift_wr  <= 1'b0;
            r_wsi       <= 1'b0;
            r_update_wr <= 1'b1;
          end else begin
            r_wsi <= w_next_bit;
          end
        end
        UPDATE: begin
          r_state      <= RESP;
          r_update_wr  <= 1'b0;
          r_select_wir <= 1'b0;
          r_rsp_valid  <= 1'b1;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            r_state     <= IDLE;
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
          end
        end
        default: begin
          r_state      <= IDLE;
          r_cmd_ready  <= 1'b1;
          r_rsp_valid  <= 1'b0;
          r_select_wir <= 1'b0;
          r_capture_wr <= 1'b0;
          r_shift_wr   <= 1'b0;
          r_update_wr  <= 1'b0;
          r_wsi        <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_ready  = r_cmd_ready;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_data   = w_rsp;
  assign bus.rsp_err    = r_rsp_err;
  assign bus.select_wir = r_select_wir;
  assign bus.capture_wr = r_capture_wr;
  assign bus.shift_wr   = r_shift_wr;
  assign bus.update_wr  = r_update_wr;
  assign bus.wsi        = r_wsi;

endmodule

// File: tb/tb_wsp_sequencer.sv
// Bench for wsp_sequencer: directed command table against a modelled wrapper
// chain, plus reset-idle and reset-during-shift sequences.
module tb_wsp_sequencer;
  import wsp_pkg::*;

  localparam int ML = 64;
  localparam int LW = $clog2(ML + 1);

  logic clk    = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  wsp_sequencer_if #(.MAX_LEN(ML)) bus ();

  wsp_sequencer #(.MAX_LEN(ML)) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus)
  );

  // Wrapper chain of clen cells: capture loads preload, shift moves toward wso.
  logic [ML-1:0] chain, upd_reg, preload;
  int            clen = 1;
  assign bus.wso = chain[0];

  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      chain   <= '0;
      upd_reg <= '0;
    end else if (bus.capture_wr) begin
      chain <= preload;
    end else if (bus.shift_wr) begin
      chain <= (chain >> 1) | ({{(ML-1){1'b0}}, bus.wsi} << (clen - 1));
    end else if (bus.update_wr) begin
      upd_reg <= chain;
    end
  end

  typedef struct {
    logic          sel;
    logic [LW-1:0] len;
    logic [ML-1:0] data;
    logic [ML-1:0] pre;
    int            clen;
    logic [ML-1:0] exp_rsp;
    logic          exp_err;
    int            exp_shifts;
    logic [ML-1:0] exp_wsi;
    logic [ML-1:0] exp_chain;
    int            hold;
  } vec_t;

  vec_t vecs [7];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int caps, upds, shifts, cap_first, upd_first, lat, viol, selbad, stbad;
    logic [ML-1:0] wsi_seq;
    caps = 0; upds = 0; shifts = 0; cap_first = -1; upd_first = -1;
    lat = -1; viol = 0; selbad = 0; stbad = 0; wsi_seq = '0;
    preload = v.pre;
    clen    = v.clen;
    @(negedge clk);
    chk({tag, " cmd_ready idle"}, 64'(bus.cmd_ready), 64'd1);
    bus.cmd_valid   = 1'b1;
    bus.cmd_sel_wir = v.sel;
    bus.cmd_len     = v.len;
    bus.cmd_data    = v.data;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (n == 1) bus.cmd_valid = 1'b0;
      if (bus.rsp_valid) begin
        lat = n;
        break;
      end
      if ((32'(bus.capture_wr) + 32'(bus.shift_wr) + 32'(bus.update_wr)) > 1) viol++;
      if (!bus.shift_wr && bus.wsi) viol++;
      if (bus.cmd_ready) viol++;
      if (bus.select_wir !== v.sel) selbad++;
      if (bus.capture_wr) begin
        caps++;
        if (cap_first < 0) cap_first = n;
      end
      if (bus.update_wr) begin
        upds++;
        if (upd_first < 0) upd_first = n;
      end
      if (bus.shift_wr) begin
        if (shifts < ML) wsi_seq[shifts] = bus.wsi;
        shifts++;
      end
    end
    chk({tag, " rsp latency"}, 64'(lat), 64'(3 + v.exp_shifts));
    chk({tag, " capture count"}, 64'(caps), 64'd1);
    chk({tag, " capture cycle"}, 64'(cap_first), 64'd1);
    chk({tag, " update count"}, 64'(upds), 64'd1);
    chk({tag, " update cycle"}, 64'(upd_first), 64'(2 + v.exp_shifts));
    chk({tag, " shift count"}, 64'(shifts), 64'(v.exp_shifts));
    chk({tag, " wsi sequence"}, wsi_seq, v.exp_wsi);
    chk({tag, " strobe rules"}, 64'(viol), 64'd0);
    chk({tag, " select_wir"}, 64'(selbad), 64'd0);
    chk({tag, " rsp_data"}, bus.rsp_data, v.exp_rsp);
    chk({tag, " rsp_err"}, 64'(bus.rsp_err), 64'(v.exp_err));
    chk({tag, " select_wir in resp"}, 64'(bus.select_wir), 64'd0);
    chk({tag, " cmd_ready in resp"}, 64'(bus.cmd_ready), 64'd0);
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== v.exp_rsp || bus.cmd_ready !== 1'b0) stbad++;
    end
    if (v.hold > 0) chk({tag, " rsp held stable"}, 64'(stbad), 64'd0);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk({tag, " rsp_valid after hs"}, 64'(bus.rsp_valid), 64'd0);
    chk({tag, " cmd_ready after hs"}, 64'(bus.cmd_ready), 64'd1);
    chk({tag, " chain updated"}, upd_reg, v.exp_chain);
  endtask

  initial begin
    int bad, nshift;
    bus.cmd_valid   = 1'b0;
    bus.cmd_sel_wir = 1'b0;
    bus.cmd_len     = '0;
    bus.cmd_data    = '0;
    bus.rsp_ready   = 1'b0;
    preload         = '0;

    //          sel   len    data                    pre                     clen exp_rsp                 err  sh  exp_wsi                 exp_chain               hold
    vecs[0] = '{1'b0, 7'd8,  64'h3C,                 64'hA5,                 8,   64'hA5,                 1'b0, 8,  64'h3C,                 64'h3C,                 0};
    vecs[1] = '{1'b1, 7'd3,  64'h5,                  64'h2,                  3,   64'h2,                  1'b0, 3,  64'h5,                  64'h5,                  0};
    vecs[2] = '{1'b0, 7'd0,  64'hFF,                 64'h1,                  1,   64'h0,                  1'b0, 0,  64'h0,                  64'h1,                  0};
    vecs[3] = '{1'b0, 7'd70, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 64, 64'hFEDC_BA98_7654_3210, 1'b1, 64, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 10};
    vecs[4] = '{1'b0, 7'd1,  64'h1,                  64'h0,                  1,   64'h0,                  1'b0, 1,  64'h1,                  64'h1,                  0};
    vecs[5] = '{1'b1, 7'd64, 64'hDEAD_BEEF_00FF_00FF, 64'h5555_5555_5555_5555, 64, 64'h5555_5555_5555_5555, 1'b0, 64, 64'hDEAD_BEEF_00FF_00FF, 64'hDEAD_BEEF_00FF_00FF, 3};
    vecs[6] = '{1'b0, 7'd5,  64'hFFFF_FFF6,          64'h0B,                 5,   64'h0B,                 1'b0, 5,  64'h16,                 64'h16,                 0};

    // Reset state and quiet idle.
    repeat (3) @(negedge clk);
    chk("reset cmd_ready", 64'(bus.cmd_ready), 64'd1);
    arst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.capture_wr !== 1'b0 ||
          bus.shift_wr !== 1'b0 || bus.update_wr !== 1'b0 || bus.select_wir !== 1'b0 ||
          bus.wsi !== 1'b0) bad++;
    end
    chk("idle 20 cycles", 64'(bad), 64'd0);
    chk("idle rsp_data", bus.rsp_data, 64'd0);
    chk("idle rsp_err", 64'(bus.rsp_err), 64'd0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Reset while the fifth shift cycle (bit 4) is in progress.
    preload = 64'hA5;
    clen    = 8;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_sel_wir = 1'b1;
    bus.cmd_len = 7'd8;
    bus.cmd_data = 64'h3C;
    nshift = 0;
    for (int n = 1; n <= 50; n++) begin
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      if (bus.shift_wr) nshift++;
      if (nshift == 5) break;
    end
    chk("reached bit 4", 64'(nshift), 64'd5);
    #1 arst_n = 1'b0;
    #1;
    chk("async strobes", {59'd0, bus.capture_wr, bus.shift_wr, bus.update_wr, bus.select_wir, bus.wsi}, 64'd0);
    chk("async cmd_ready", 64'(bus.cmd_ready), 64'd1);
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b0) bad++;
    end
    arst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b0 || bus.shift_wr !== 1'b0) bad++;
    end
    chk("no rsp after reset", 64'(bad), 64'd0);
    run_vec(vecs[0], "post-reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
